// File: rtl/cdb_broadcaster_pkg.sv
// Shared definitions for the CDB broadcaster slice.
// Holds the default sizing of the bus and its producers. It also holds the
// wrap-around increment that the round-robin pointer uses.
package cdb_broadcaster_pkg;

    localparam int unsigned CDB_NUM_FU_DEFAULT         = 4;
    localparam int unsigned CDB_ROB_ADDR_WIDTH_DEFAULT = 5;
    localparam int unsigned CDB_DATA_WIDTH_DEFAULT     = 32;

    // (idx + 1) mod n, without a divider.
    function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req      - per-requester request bits
//   ptr      - index that currently holds highest priority
//   advance  - allow next_ptr to move past the winner
//   grant    - one-hot grant (all zero when nothing requests)
//   next_ptr - winner + 1 (mod N) when advancing and a grant exists, else ptr
module rr_arbiter
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = PW'((32'(ptr) + off) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                if (advance) begin
                    next_ptr = PW'(rr_wrap_inc(32'(idx), N));
                end
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus transmitter.
// Each functional unit hands its result to a one-entry slot over a
// valid/ready handshake. A round-robin arbiter picks one pending slot per
// cycle. The winner is registered onto the bus: a main channel plus a lo
// channel for hi/lo producers.
// Ports:
//   clk, rst (sync, active-low), flush_en (drop all pending work)
//   fu_valid/fu_ready          - per-unit handshake
//   fu_rob_addr/fu_data        - packed main result per unit
//   fu_lo_en/fu_lo_rob_addr/fu_lo_data - packed lo half per unit
//   bus_en/bus_ref_id_out/bus_data_out             - main broadcast
//   bus_lo_en/bus_lo_ref_id_out/bus_lo_data_out    - lo broadcast
//   busy                       - any slot pending or a broadcast on the bus
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
#(
    parameter int unsigned NUM_FU         = CDB_NUM_FU_DEFAULT,
    parameter int unsigned ROB_ADDR_WIDTH = CDB_ROB_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH     = CDB_DATA_WIDTH_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_en,
    input  logic [NUM_FU-1:0]                fu_valid,
    output logic [NUM_FU-1:0]                fu_ready,
    input  logic [NUM_FU*ROB_ADDR_WIDTH-1:0] fu_rob_addr,
    input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data,
    input  logic [NUM_FU-1:0]                fu_lo_en,
    input  logic [NUM_FU*ROB_ADDR_WIDTH-1:0] fu_lo_rob_addr,
    input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_lo_data,
    output logic                             bus_en,
    output logic [DATA_WIDTH-1:0]            bus_ref_id_out,
    output logic [DATA_WIDTH-1:0]            bus_data_out,
    output logic                             bus_lo_en,
    output logic [DATA_WIDTH-1:0]            bus_lo_ref_id_out,
    output logic [DATA_WIDTH-1:0]            bus_lo_data_out,
    output logic                             busy
);

    localparam int unsigned PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]         pending;
    logic [NUM_FU-1:0]         slot_lo_en;
    logic [ROB_ADDR_WIDTH-1:0] slot_rob_addr    [NUM_FU];
    logic [DATA_WIDTH-1:0]     slot_data        [NUM_FU];
    logic [ROB_ADDR_WIDTH-1:0] slot_lo_rob_addr [NUM_FU];
    logic [DATA_WIDTH-1:0]     slot_lo_data     [NUM_FU];

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     next_ptr;
    logic [NUM_FU-1:0] grant;
    logic [PW-1:0]     gsel;

    rr_arbiter #(.N(NUM_FU)) u_arb (
        .req      (pending),
        .ptr      (ptr),
        .advance  (!flush_en),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // A slot being granted this edge empties, so it may refill on the same edge.
    assign fu_ready = ~pending | grant;
    assign busy     = (|pending) | bus_en;

    always_comb begin
        gsel = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (grant[i]) begin
                gsel = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending           <= '0;
            slot_lo_en        <= '0;
            ptr               <= '0;
            bus_en            <= 1'b0;
            bus_lo_en         <= 1'b0;
            bus_ref_id_out    <= '0;
            bus_data_out      <= '0;
            bus_lo_ref_id_out <= '0;
            bus_lo_data_out   <= '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                slot_rob_addr[i]    <= '0;
                slot_data[i]        <= '0;
                slot_lo_rob_addr[i] <= '0;
                slot_lo_data[i]     <= '0;
            end
        end else if (flush_en) begin
            // Same-edge handshakes are dropped: slot contents are not loaded.
            pending           <= '0;
            ptr               <= '0;
            bus_en            <= 1'b0;
            bus_lo_en         <= 1'b0;
            bus_lo_ref_id_out <= '0;
            bus_lo_data_out   <= '0;
        end else begin
            ptr <= next_ptr;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    pending[i]          <= 1'b1;
                    slot_rob_addr[i]    <= fu_rob_addr[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
                    slot_data[i]        <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
                    slot_lo_en[i]       <= fu_lo_en[i];
                    slot_lo_rob_addr[i] <= fu_lo_rob_addr[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
                    slot_lo_data[i]     <= fu_lo_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (grant[i]) begin
                    pending[i] <= 1'b0;
                end
            end

            if (|grant) begin
                bus_en         <= 1'b1;
                bus_ref_id_out <= DATA_WIDTH'(slot_rob_addr[gsel]);
                bus_data_out   <= slot_data[gsel];
                bus_lo_en      <= slot_lo_en[gsel];
                if (slot_lo_en[gsel]) begin
                    bus_lo_ref_id_out <= DATA_WIDTH'(slot_lo_rob_addr[gsel]);
                    bus_lo_data_out   <= slot_lo_data[gsel];
                end else begin
                    bus_lo_ref_id_out <= '0;
                    bus_lo_data_out   <= '0;
                end
            end else begin
                // Main data is left stale; lo is zeroed whenever lo is not valid.
                bus_en            <= 1'b0;
                bus_lo_en         <= 1'b0;
                bus_lo_ref_id_out <= '0;
                bus_lo_data_out   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios plus a random
// phase, all compared against a transaction-level model of slots and pointer.
module tb_cdb_broadcaster;

    localparam int NF = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic              flush_en;
    logic [NF-1:0]     fu_valid;
    logic [NF-1:0]     fu_ready;
    logic [NF*AW-1:0]  fu_rob_addr;
    logic [NF*DW-1:0]  fu_data;
    logic [NF-1:0]     fu_lo_en;
    logic [NF*AW-1:0]  fu_lo_rob_addr;
    logic [NF*DW-1:0]  fu_lo_data;
    logic              bus_en;
    logic [DW-1:0]     bus_ref_id_out;
    logic [DW-1:0]     bus_data_out;
    logic              bus_lo_en;
    logic [DW-1:0]     bus_lo_ref_id_out;
    logic [DW-1:0]     bus_lo_data_out;
    logic              busy;

    cdb_broadcaster #(.NUM_FU(NF), .ROB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_en          (flush_en),
        .fu_valid          (fu_valid),
        .fu_ready          (fu_ready),
        .fu_rob_addr       (fu_rob_addr),
        .fu_data           (fu_data),
        .fu_lo_en          (fu_lo_en),
        .fu_lo_rob_addr    (fu_lo_rob_addr),
        .fu_lo_data        (fu_lo_data),
        .bus_en            (bus_en),
        .bus_ref_id_out    (bus_ref_id_out),
        .bus_data_out      (bus_data_out),
        .bus_lo_en         (bus_lo_en),
        .bus_lo_ref_id_out (bus_lo_ref_id_out),
        .bus_lo_data_out   (bus_lo_data_out),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Model: each unit owns at most one waiting result; the bus shows
    // whichever result was chosen at the previous edge.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          lo_en;
        logic [AW-1:0] lo_addr;
        logic [DW-1:0] lo_data;
    } result_t;

    bit      m_waiting [NF];
    result_t m_slot    [NF];
    int      m_next;          // unit with highest priority for the next pick
    bit      m_on_bus;
    result_t m_bus;

    function automatic int model_pick();
        for (int k = 0; k < NF; k++) begin
            if (m_waiting[(m_next + k) % NF]) return (m_next + k) % NF;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int  pick;
        bit  acc [NF];
        pick = model_pick();
        for (int i = 0; i < NF; i++) acc[i] = fu_valid[i] && (!m_waiting[i] || pick == i);
        if (!rst) begin
            for (int i = 0; i < NF; i++) m_waiting[i] = 0;
            m_next   = 0;
            m_on_bus = 0;
        end else if (flush_en) begin
            for (int i = 0; i < NF; i++) m_waiting[i] = 0;
            m_next   = 0;
            m_on_bus = 0;
        end else begin
            m_on_bus = (pick >= 0);
            if (pick >= 0) begin
                m_bus            = m_slot[pick];
                m_waiting[pick]  = 0;
                m_next           = (pick + 1) % NF;
            end
            for (int i = 0; i < NF; i++) begin
                if (acc[i]) begin
                    m_waiting[i]      = 1;
                    m_slot[i].addr    = fu_rob_addr[i*AW +: AW];
                    m_slot[i].data    = fu_data[i*DW +: DW];
                    m_slot[i].lo_en   = fu_lo_en[i];
                    m_slot[i].lo_addr = fu_lo_rob_addr[i*AW +: AW];
                    m_slot[i].lo_data = fu_lo_data[i*DW +: DW];
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NF-1:0] exp_ready;
        bit            any;
        int            pick;
        pick = model_pick();
        any  = m_on_bus;
        for (int i = 0; i < NF; i++) begin
            exp_ready[i] = !m_waiting[i] || pick == i;
            any          = any || m_waiting[i];
        end
        check("bus_en", 64'(bus_en), 64'(m_on_bus));
        check("bus_lo_en", 64'(bus_lo_en), 64'(m_on_bus && m_bus.lo_en));
        check("fu_ready", 64'(fu_ready), 64'(exp_ready));
        check("busy", 64'(busy), 64'(any));
        if (m_on_bus) begin
            check("bus_ref", 64'(bus_ref_id_out), 64'(m_bus.addr));
            check("bus_data", 64'(bus_data_out), 64'(m_bus.data));
            check("lo_ref", 64'(bus_lo_ref_id_out), m_bus.lo_en ? 64'(m_bus.lo_addr) : 64'd0);
            check("lo_data", 64'(bus_lo_data_out), m_bus.lo_en ? 64'(m_bus.lo_data) : 64'd0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_fu(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic le, input logic [AW-1:0] la, input logic [DW-1:0] ld);
        fu_valid[i]              = v;
        fu_rob_addr[i*AW +: AW]  = a;
        fu_data[i*DW +: DW]      = d;
        fu_lo_en[i]              = le;
        fu_lo_rob_addr[i*AW +: AW] = la;
        fu_lo_data[i*DW +: DW]   = ld;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        idle_all();
        flush_en = 1'b0;
        rst      = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        flush_en = 1'b0;
        idle_all();
        @(negedge clk);

        // Reset then idle
        do_reset();
        check("rst_bus_en", 64'(bus_en), 64'd0);
        check("rst_lo_en", 64'(bus_lo_en), 64'd0);
        check("rst_outs", 64'(bus_ref_id_out | bus_data_out | bus_lo_ref_id_out | bus_lo_data_out), 64'd0);
        check("rst_ready", 64'(fu_ready), 64'hF);
        check("rst_busy", 64'(busy), 64'd0);
        step();

        // Single result on FU1
        set_fu(1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, '0);
        step();
        check("single_e0", 64'(bus_en), 64'd0);
        idle_all();
        step();
        check("single_en", 64'(bus_en), 64'd1);
        check("single_ref", 64'(bus_ref_id_out), 64'd7);
        check("single_data", 64'(bus_data_out), 64'hDEADBEEF);
        check("single_lo", 64'(bus_lo_en), 64'd0);
        step();
        check("single_once", 64'(bus_en), 64'd0);

        // Hi/lo pair on FU3
        set_fu(3, 1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
        step();
        idle_all();
        step();
        check("hilo_en", 64'(bus_en), 64'd1);
        check("hilo_ref", 64'(bus_ref_id_out), 64'd3);
        check("hilo_data", 64'(bus_data_out), 64'h1);
        check("hilo_lo_en", 64'(bus_lo_en), 64'd1);
        check("hilo_lo_ref", 64'(bus_lo_ref_id_out), 64'd4);
        check("hilo_lo_data", 64'(bus_lo_data_out), 64'h2);
        step();

        // Round-robin fairness, all units streaming
        do_reset();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, AW'(10 + i), $urandom, 1'b0, '0, '0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("rr_ready", 64'(fu_ready), 64'(4'b0001 << ((k - 1) % NF)));
            if (k >= 2) begin
                check("rr_en", 64'(bus_en), 64'd1);
                check("rr_order", 64'(bus_ref_id_out), 64'(10 + (k - 2) % NF));
            end
        end

        // Backpressure: FU0 re-presents while FU2 waits
        do_reset();
        set_fu(0, 1'b1, 5'd20, 32'hA0, 1'b0, '0, '0);
        set_fu(2, 1'b1, 5'd30, 32'hC0, 1'b0, '0, '0);
        step();
        set_fu(0, 1'b1, 5'd21, 32'hA1, 1'b0, '0, '0);
        set_fu(2, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        idle_all();
        check("bp_first", 64'(bus_ref_id_out), 64'd20);
        check("bp_ready0_low", 64'(fu_ready[0]), 64'd0);
        step();
        check("bp_second", 64'(bus_ref_id_out), 64'd30);
        step();
        check("bp_third", 64'(bus_ref_id_out), 64'd21);
        step();
        check("bp_drained", 64'(bus_en), 64'd0);

        // Flush mid-operation
        do_reset();
        set_fu(0, 1'b1, 5'd1, 32'h11, 1'b0, '0, '0);
        set_fu(2, 1'b1, 5'd2, 32'h22, 1'b0, '0, '0);
        set_fu(3, 1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
        step();
        set_fu(0, 1'b1, 5'd8, 32'h88, 1'b0, '0, '0);
        set_fu(2, 1'b0, '0, '0, 1'b0, '0, '0);
        set_fu(3, 1'b0, '0, '0, 1'b0, '0, '0);
        step();
        idle_all();
        set_fu(1, 1'b1, 5'd15, 32'hFF, 1'b0, '0, '0);
        flush_en = 1'b1;
        step();
        flush_en = 1'b0;
        idle_all();
        check("flush_en_low", 64'(bus_en), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        step();
        check("flush_quiet", 64'(bus_en), 64'd0);
        set_fu(0, 1'b1, 5'd5, 32'h55, 1'b0, '0, '0);
        set_fu(3, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
        step();
        idle_all();
        step();
        check("post_flush_fu0", 64'(bus_ref_id_out), 64'd5);
        step();
        check("post_flush_fu3", 64'(bus_ref_id_out), 64'd6);
        step();

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NF; i++)
                set_fu(i, $urandom_range(0, 2) != 0, AW'($urandom), $urandom,
                       1'($urandom), AW'($urandom), $urandom);
            flush_en = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 127) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
